// File: rtl/parity_frame_rx.sv
// parity_frame_rx
// Serial frame receiver that feeds a downstream parity checker stage.
// Frame on rx_i: start(0), DATA_BITS data bits LSB first, parity bit, stop(1).
// The parity bit is passed through untouched; checking happens downstream.
//
// Ports:
//   wb_clk_i     in   1            sole clock, rising edge
//   wb_rst_i     in   1            synchronous active-high reset
//   rx_i         in   1            serial line, idle high
//   clkdiv_i     in   16           bit period in clock cycles (0-3 behave as 4)
//   ready_i      in   1            downstream accepts word_o this cycle
//   word_o       out  DATA_BITS+1  {parity, data}
//   valid_o      out  1            word_o holds an unconsumed word
//   frame_err_o  out  1            one-cycle pulse: stop bit sampled 0
//   overrun_o    out  1            one-cycle pulse: completed word dropped
//   busy_o       out  1            receiver is inside a frame
//
// Configuration macro:
//   PRX_SYNC_EN  defined: rx_i passes a two-flop synchronizer before the line
//                register (two extra cycles of detection latency).
//                undefined: rx_i is registered by the line register only.
//
// DATA_BITS must be at least 2.

module parity_frame_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 rx_i,
  input  logic [15:0]          clkdiv_i,
  input  logic                 ready_i,
  output logic [DATA_BITS:0]   word_o,
  output logic                 valid_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_line;
  logic                  r_prev;
  logic [15:0]           r_cnt;
  logic [15:0]           r_period;
  logic [CW-1:0]         r_bitcnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_par;
  logic [DATA_BITS:0]    r_word;
  logic                  r_valid;
  logic                  r_ferr;
  logic                  r_ovr;
  logic                  r_busy;

  logic                  w_line_in;
  logic [15:0]           w_eff;
  logic                  w_expire;
  logic                  w_start;

`ifdef PRX_SYNC_EN
  logic [1:0]            r_sync;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx_i};
    end
  end

  assign w_line_in = r_sync[1];
`else
  assign w_line_in = rx_i;
`endif

  // Line register plus its previous sample, used for falling-edge start detection.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_line <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_line <= w_line_in;
      r_prev <= r_line;
    end
  end

  // Effective bit period, counter expiry and start-edge decode.
  always_comb begin
    w_eff    = (clkdiv_i < 16'd4) ? 16'd4 : clkdiv_i;
    w_expire = (r_cnt <= 16'd1);
    // The edge requirement also means the line must be seen high again after
    // a frame error before another frame can begin.
    w_start  = (~r_line) & r_prev;
  end

  // Receive FSM together with the output holding register and status pulses.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= IDLE;
      r_cnt    <= 16'd0;
      r_period <= 16'd0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_word   <= '0;
      r_valid  <= 1'b0;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;

      // Acceptance frees the holding register; a word completing this same
      // cycle (STOP branch below) refills it and keeps valid high.
      if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end

      // Expiry branches below override this with a reload.
      if (r_state != IDLE) begin
        r_cnt <= r_cnt - 16'd1;
      end

      case (r_state)
        IDLE: begin
          if (w_start) begin
            // Half a period lands the START check in the middle of the bit.
            r_cnt    <= w_eff >> 1;
            r_period <= w_eff;
            r_bitcnt <= '0;
            r_state  <= START;
            r_busy   <= 1'b1;
          end
        end
        START: begin
          if (w_expire) begin
            if (r_line) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_cnt   <= r_period;
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_expire) begin
            r_shift <= {r_line, r_shift[DATA_BITS-1:1]};
            r_cnt   <= r_period;
            if (r_bitcnt == LAST_BIT) begin
              r_state <= PARITY;
            end else begin
              r_bitcnt <= r_bitcnt + CW'(1);
            end
          end
        end
        PARITY: begin
          if (w_expire) begin
            r_par   <= r_line;
            r_cnt   <= r_period;
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_expire) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (r_line) begin
              if (!r_valid || ready_i) begin
                r_word  <= {r_par, r_shift};
                r_valid <= 1'b1;
              end else begin
                r_ovr <= 1'b1;
              end
            end else begin
              r_ferr <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign word_o      = r_word;
  assign valid_o     = r_valid;
  assign frame_err_o = r_ferr;
  assign overrun_o   = r_ovr;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx: directed corner sequences, a
// table of single frames, and a randomized run against a frame-level model.
module tb_parity_frame_rx;

  localparam int DB   = 8;
  localparam int WW   = DB + 1;
  localparam int TMAX = 1024;
`ifdef PRX_SYNC_EN
  localparam int LAT  = 3;
`else
  localparam int LAT  = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic [15:0]   cd;
  logic          rdy;
  logic [WW-1:0] word;
  logic          valid;
  logic          ferr;
  logic          ovr;
  logic          busy;

  parity_frame_rx #(.DATA_BITS(DB)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .rx_i        (rx),
    .clkdiv_i    (cd),
    .ready_i     (rdy),
    .word_o      (word),
    .valid_o     (valid),
    .frame_err_o (ferr),
    .overrun_o   (ovr),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor (samples on the falling edge) ----------------
  int            n_ferr = 0;
  int            n_ovr  = 0;
  int            n_vhi  = 0;
  logic [WW-1:0] acc_q[$];
  bit            chk_stab = 1'b0;
  bit            pv   = 1'b0;
  bit            pacc = 1'b0;
  logic [WW-1:0] pword = '0;

  always @(negedge clk) begin
    if (ferr === 1'b1) n_ferr++;
    if (ovr === 1'b1) n_ovr++;
    if (valid === 1'b1) n_vhi++;
    if (valid === 1'b1 && rdy === 1'b1 && rst !== 1'b1) acc_q.push_back(word);
    if (chk_stab && pv && !pacc) begin
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_word", 32'(word), 32'(pword));
    end
    pv    = (valid === 1'b1);
    pacc  = pv && (rdy === 1'b1);
    pword = word;
  end

  // ---------------- traces indexed by cycle within the current frame -----
  int            k = 0;
  logic          vtr[TMAX];
  logic          btr[TMAX];
  logic          ftr[TMAX];
  logic          otr[TMAX];
  logic [WW-1:0] wtr[TMAX];

  task automatic tick();
    @(posedge clk);
    #1;
    if (k < TMAX) begin
      vtr[k] = valid;
      btr[k] = busy;
      ftr[k] = ferr;
      otr[k] = ovr;
      wtr[k] = word;
    end
    k++;
  endtask

  int rdy_mode = 0;   // 0: leave rdy alone, 1: random, 2: high only at rdy_at
  int rdy_at   = -1;
  int rst_at   = -1;
  bit cd_scr   = 1'b0;

  task automatic drive_cycle(input logic line);
    rx  = line;
    rst = (k == rst_at);
    if (rdy_mode == 1) rdy = 1'($urandom_range(0, 1));
    else if (rdy_mode == 2) rdy = (k == rdy_at);
    if (cd_scr && k > LAT + 1) cd = 16'($urandom);
    tick();
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic s,
                            input logic [15:0] cdv);
    int e = (cdv < 16'd4) ? 4 : int'(cdv);
    logic [DB+2:0] bits;
    bits = {s, p, d, 1'b0};
    cd = cdv;
    k  = 0;
    for (int b = 0; b < DB + 3; b++)
      for (int c = 0; c < e; c++) drive_cycle(bits[b]);
  endtask

  task automatic idle(input int n, input logic line);
    for (int c = 0; c < n; c++) drive_cycle(line);
  endtask

  // Edge at which the stop bit is sampled, counted from the start-bit drive.
  function automatic int ks(input int e);
    return LAT + e / 2 + e * (DB + 2);
  endfunction

  function automatic int sum_tr(input int which, input int lo, input int hi);
    int s = 0;
    for (int i = lo; i <= hi; i++) begin
      case (which)
        0: s += int'(vtr[i]);
        1: s += int'(btr[i]);
        2: s += int'(ftr[i]);
        default: s += int'(otr[i]);
      endcase
    end
    return s;
  endfunction

  typedef struct {
    logic [DB-1:0] d;
    logic          p;
    logic          s;
    logic [15:0]   cdv;
    logic [WW-1:0] exp_word;
    int            exp_ok;
    int            exp_ferr;
  } vec_t;

  vec_t          vt[7];
  logic [15:0]   cdl[7];
  logic [WW-1:0] exp_q[$];

  initial begin
    int s, f0, v0, o0, ferr_exp, nmin;
    logic [DB-1:0] rd;
    logic rp, rs;

    vt[0] = '{8'h5A, 1'b1, 1'b1, 16'd16, 9'h15A, 1, 0};
    vt[1] = '{8'h00, 1'b1, 1'b1, 16'd4,  9'h100, 1, 0};
    vt[2] = '{8'hFF, 1'b0, 1'b1, 16'd0,  9'h0FF, 1, 0};
    vt[3] = '{8'h81, 1'b1, 1'b1, 16'd3,  9'h181, 1, 0};
    vt[4] = '{8'hC3, 1'b0, 1'b1, 16'd5,  9'h0C3, 1, 0};
    vt[5] = '{8'h7E, 1'b1, 1'b0, 16'd9,  9'h000, 0, 1};
    vt[6] = '{8'h01, 1'b0, 1'b1, 16'd23, 9'h001, 1, 0};
    cdl   = '{16'd0, 16'd2, 16'd4, 16'd5, 16'd7, 16'd11, 16'd16};

    // ---- reset state ----
    rst = 1'b1; rx = 1'b1; rdy = 1'b0; cd = 16'd16;
    repeat (3) @(posedge clk);
    #1;
    check("rst_word", 32'(word), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(5, 1'b1);

    // ---- 0xA5 / parity 0: valid one cycle after the stop sample ----
    acc_q.delete();
    send_frame(8'hA5, 1'b0, 1'b1, 16'd16);
    idle(12, 1'b1);
    s = ks(16);
    check("a5_valid_before_stop", 32'(vtr[s-1]), 32'd0);
    check("a5_valid_after_stop", 32'(vtr[s]), 32'd1);
    check("a5_busy_after_stop", 32'(btr[s]), 32'd0);
    check("a5_word", 32'(word), 32'h0A5);
    rdy = 1'b1;
    idle(3, 1'b1);
    check("a5_accept_count", 32'(acc_q.size()), 32'd1);
    check("a5_accept_word", 32'((acc_q.size() > 0) ? acc_q[0] : 9'h1FF), 32'h0A5);

    // ---- table of single frames, ready held high ----
    for (int i = 0; i < 7; i++) begin
      acc_q.delete();
      f0 = n_ferr;
      v0 = n_vhi;
      send_frame(vt[i].d, vt[i].p, vt[i].s, vt[i].cdv);
      idle(12, 1'b1);
      check($sformatf("vec%0d_count", i), 32'(acc_q.size()), 32'(vt[i].exp_ok));
      if (vt[i].exp_ok == 1)
        check($sformatf("vec%0d_word", i), 32'((acc_q.size() > 0) ? acc_q[0] : 9'h1FF),
              32'(vt[i].exp_word));
      check($sformatf("vec%0d_valid_cycles", i), 32'(n_vhi - v0), 32'(vt[i].exp_ok));
      check($sformatf("vec%0d_ferr", i), 32'(n_ferr - f0), 32'(vt[i].exp_ferr));
    end

    // ---- false start: line low 5 cycles then high ----
    acc_q.delete();
    f0 = n_ferr;
    cd = 16'd16;
    k  = 0;
    idle(5, 1'b0);
    idle(30, 1'b1);
    check("fs_busy_len_le8", 32'(sum_tr(1, 0, 34) >= 1 && sum_tr(1, 0, 34) <= 8), 32'd1);
    check("fs_busy_midbit", 32'(btr[LAT+7]), 32'd1);
    check("fs_busy_cleared", 32'(btr[LAT+8]), 32'd0);
    check("fs_no_word", 32'(acc_q.size()), 32'd0);
    check("fs_no_ferr", 32'(n_ferr - f0), 32'd0);

    // ---- stop bit 0: frame error, line held low blocks new frames ----
    acc_q.delete();
    f0 = n_ferr;
    v0 = n_vhi;
    send_frame(8'h3C, 1'b0, 1'b0, 16'd16);
    idle(48, 1'b0);
    check("fe_pulse", 32'(n_ferr - f0), 32'd1);
    check("fe_no_valid", 32'(n_vhi - v0), 32'd0);
    check("fe_idle_while_low", 32'(sum_tr(1, 176, 223)), 32'd0);
    idle(20, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1, 16'd16);
    idle(12, 1'b1);
    check("fe_recover_word", 32'((acc_q.size() > 0) ? acc_q[0] : 9'h1FF), 32'h03C);

    // ---- overrun, then completion in the same cycle as acceptance ----
    acc_q.delete();
    o0  = n_ovr;
    rdy = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 16'd16);
    idle(12, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 16'd16);
    idle(12, 1'b1);
    check("ovr_pulse", 32'(n_ovr - o0), 32'd1);
    check("ovr_word_kept", 32'(word), 32'h011);
    check("ovr_valid_kept", 32'(valid), 32'd1);
    s        = ks(16);
    rdy_mode = 2;
    rdy_at   = s;
    send_frame(8'h33, 1'b0, 1'b1, 16'd16);
    idle(12, 1'b1);
    rdy_mode = 0;
    check("same_valid_before", 32'(vtr[s-1]), 32'd1);
    check("same_valid_after", 32'(vtr[s]), 32'd1);
    check("same_word", 32'(wtr[s]), 32'h033);
    check("same_old_accepted", 32'((acc_q.size() > 0) ? acc_q[0] : 9'h1FF), 32'h011);
    check("same_no_ovr", 32'(n_ovr - o0), 32'd1);
    rdy = 1'b1;
    idle(3, 1'b1);
    check("same_drain", 32'((acc_q.size() > 1) ? acc_q[1] : 9'h1FF), 32'h033);

    // ---- reset during DATA of frame 0xFF, then clean frame 0x81 ----
    rdy = 1'b0;
    send_frame(8'h42, 1'b1, 1'b1, 16'd16);
    idle(12, 1'b1);
    check("pre_rst_word", 32'(word), 32'h142);
    rst_at = LAT + 8 + 16 * 3;
    send_frame(8'hFF, 1'b1, 1'b1, 16'd16);
    idle(12, 1'b1);
    check("mrst_word", 32'(wtr[rst_at]), 32'd0);
    check("mrst_valid", 32'(vtr[rst_at]), 32'd0);
    check("mrst_busy", 32'(btr[rst_at]), 32'd0);
    check("mrst_ferr", 32'(ftr[rst_at]), 32'd0);
    check("mrst_ovr", 32'(otr[rst_at]), 32'd0);
    check("mrst_quiet", 32'(sum_tr(0, rst_at, 187) + sum_tr(1, rst_at, 187) +
                             sum_tr(2, rst_at, 187) + sum_tr(3, rst_at, 187)), 32'd0);
    rst_at = -1;
    acc_q.delete();
    rdy = 1'b1;
    send_frame(8'h81, 1'b0, 1'b1, 16'd16);
    idle(12, 1'b1);
    s = ks(16);
    check("post_rst_lat_before", 32'(vtr[s-1]), 32'd0);
    check("post_rst_lat_at", 32'(vtr[s]), 32'd1);
    check("post_rst_one_cycle", 32'(vtr[s+1]), 32'd0);
    check("post_rst_word", 32'((acc_q.size() > 0) ? acc_q[0] : 9'h1FF), 32'h081);

    // ---- randomized frames against a frame-level model ----
    acc_q.delete();
    exp_q.delete();
    f0       = n_ferr;
    o0       = n_ovr;
    ferr_exp = 0;
    chk_stab = 1'b1;
    cd_scr   = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rd = 8'($urandom);
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 5) != 0);
      if (rs) exp_q.push_back({rp, rd});
      else ferr_exp++;
      rdy_mode = 1;
      send_frame(rd, rp, rs, cdl[$urandom_range(0, 6)]);
      rdy_mode = 0;
      rdy      = 1'b1;
      idle(6 + int'($urandom_range(0, 6)), 1'b1);
    end
    chk_stab = 1'b0;
    cd_scr   = 1'b0;
    check("rnd_count", 32'(acc_q.size()), 32'(exp_q.size()));
    nmin = (acc_q.size() < exp_q.size()) ? acc_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++)
      check($sformatf("rnd_word%0d", i), 32'(acc_q[i]), 32'(exp_q[i]));
    check("rnd_ferr", 32'(n_ferr - f0), 32'(ferr_exp));
    check("rnd_no_ovr", 32'(n_ovr - o0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
